// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module   : branch_resolve_unit
// Purpose  : Execute-side partner of branch_predictor. Queues predicted
//            branches between fetch and execute. Compares each prediction
//            with the ALU outcome, drives the predictor update strobe, and
//            raises a one-cycle flush with the corrected fetch address when
//            a branch was mispredicted. Also keeps saturating branch and
//            mispredict statistics.
// Ports    : i_Clk, i_Reset_n (synchronous, active-high despite the name)
//            i_IF_*            fetch-side push (pc, prediction, target)
//            o_IF_stall        FIFO full
//            i_EX_resolve/outcome  execute-side pop and actual direction
//            o_ALU_*           registered update to the predictor
//            o_flush/o_redirect_pc  mispredict recovery
//            o_count, o_error, o_branches, o_mispredicts  status
// Revision : 1.0  initial release
// ============================================================================
module branch_resolve_unit #(
    parameter int PC_W  = 22,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_IF_isbranch,
    input  logic [PC_W-1:0]          i_IF_pc,
    input  logic                     i_IF_prediction,
    input  logic [PC_W-1:0]          i_IF_target,
    output logic                     o_IF_stall,
    input  logic                     i_EX_resolve,
    input  logic                     i_EX_outcome,
    output logic                     o_ALU_isbranch,
    output logic [PC_W-1:0]          o_ALU_pc,
    output logic                     o_ALU_prediction,
    output logic                     o_ALU_outcome,
    output logic                     o_flush,
    output logic [PC_W-1:0]          o_redirect_pc,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_error,
    output logic [CNT_W-1:0]         o_branches,
    output logic [CNT_W-1:0]         o_mispredicts
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] c_FULL = OCC_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_SAT  = '1;

    // Entry storage; not reset, occupancy alone says what is valid.
    logic [PC_W-1:0]  r_mem_pc   [DEPTH];
    logic             r_mem_pred [DEPTH];
    logic [PC_W-1:0]  r_mem_tgt  [DEPTH];

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [OCC_W-1:0] r_count;

    logic             r_alu_isbranch;
    logic [PC_W-1:0]  r_alu_pc;
    logic             r_alu_prediction;
    logic             r_alu_outcome;
    logic             r_flush;
    logic [PC_W-1:0]  r_redirect_pc;
    logic             r_error;
    logic [CNT_W-1:0] r_branches;
    logic [CNT_W-1:0] r_mispredicts;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_mispredict;
    logic             w_error_evt;
    logic [PC_W-1:0]  w_head_pc;
    logic             w_head_pred;
    logic [PC_W-1:0]  w_head_tgt;

    always_comb begin
        w_full       = (r_count == c_FULL);
        w_empty      = (r_count == '0);
        w_pop        = i_EX_resolve && !w_empty;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        w_push       = i_IF_isbranch && (!w_full || w_pop);
        w_head_pc    = r_mem_pc[r_head];
        w_head_pred  = r_mem_pred[r_head];
        w_head_tgt   = r_mem_tgt[r_head];
        w_mispredict = w_pop && (w_head_pred != i_EX_outcome);
        w_error_evt  = (i_EX_resolve && w_empty) ||
                       (i_IF_isbranch && w_full && !w_pop);
    end

    // Storage write. On a mispredict the written entry is wrong-path, but the
    // pointers are cleared in the same edge so it is never read back.
    always_ff @(posedge i_Clk) begin
        if (w_push) begin
            r_mem_pc[r_tail]   <= i_IF_pc;
            r_mem_pred[r_tail] <= i_IF_prediction;
            r_mem_tgt[r_tail]  <= i_IF_target;
        end
    end

    // Pointers and occupancy. Pointers wrap naturally since DEPTH is 2^PTR_W.
    always_ff @(posedge i_Clk) begin
        if (i_Reset_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_mispredict) begin
            // Everything younger than the mispredicted branch is wrong-path.
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + OCC_W'(1);
                2'b01:   r_count <= r_count - OCC_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Resolution outputs, recovery and statistics.
    always_ff @(posedge i_Clk) begin
        if (i_Reset_n) begin
            r_alu_isbranch   <= 1'b0;
            r_alu_pc         <= '0;
            r_alu_prediction <= 1'b0;
            r_alu_outcome    <= 1'b0;
            r_flush          <= 1'b0;
            r_redirect_pc    <= '0;
            r_error          <= 1'b0;
            r_branches       <= '0;
            r_mispredicts    <= '0;
        end else begin
            r_alu_isbranch <= w_pop;
            r_flush        <= w_mispredict;
            if (w_pop) begin
                r_alu_pc         <= w_head_pc;
                r_alu_prediction <= w_head_pred;
                r_alu_outcome    <= i_EX_outcome;
                if (r_branches != c_SAT) begin
                    r_branches <= r_branches + CNT_W'(1);
                end
            end
            if (w_mispredict) begin
                // Fall-through address wraps modulo 2^PC_W.
                r_redirect_pc <= i_EX_outcome ? w_head_tgt : (w_head_pc + PC_W'(1));
                if (r_mispredicts != c_SAT) begin
                    r_mispredicts <= r_mispredicts + CNT_W'(1);
                end
            end
            if (w_error_evt) begin
                r_error <= 1'b1;
            end
        end
    end

    assign o_IF_stall       = w_full;
    assign o_count          = r_count;
    assign o_ALU_isbranch   = r_alu_isbranch;
    assign o_ALU_pc         = r_alu_pc;
    assign o_ALU_prediction = r_alu_prediction;
    assign o_ALU_outcome    = r_alu_outcome;
    assign o_flush          = r_flush;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_error          = r_error;
    assign o_branches       = r_branches;
    assign o_mispredicts    = r_mispredicts;

endmodule
`default_nettype wire

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Execute-side partner of branch_predictor; consumes the fetch-stage prediction stream and closes the loop.
- Holds in-flight predicted branches in a FIFO from fetch to execute, then compares each prediction with the ALU outcome.
- Drives branch_predictor's update inputs (i_ALU_pc/isbranch/prediction/outcome) and generates the pipeline flush and redirect PC.
- Keeps saturating branch and mispredict statistics.

Parameters:
PC_W, 22, instruction address width (word addresses).
DEPTH, 4, in-flight branch FIFO entries; power of two, ≥2.
CNT_W, 16, statistics counter width.

Ports:
i_Clk  in  1  clock; all state changes on the rising edge.
i_Reset_n  in  1  synchronous, active-high reset (the name is kept despite the _n suffix).
i_IF_isbranch  in  1  fetch issued a branch this cycle; push request.
i_IF_pc  in  PC_W  PC of the fetched branch.
i_IF_prediction  in  1  predictor's o_taken for that branch.
i_IF_target  in  PC_W  taken-target of the branch.
o_IF_stall  out  1  FIFO full; combinational.
i_EX_resolve  in  1  oldest branch resolves in the ALU this cycle; pop request.
i_EX_outcome  in  1  actual direction (1 = taken).
o_ALU_isbranch  out  1  registered update strobe to the predictor.
o_ALU_pc  out  PC_W  PC of the resolved branch.
o_ALU_prediction  out  1  stored prediction.
o_ALU_outcome  out  1  registered i_EX_outcome.
o_flush  out  1  one-cycle mispredict pulse.
o_redirect_pc  out  PC_W  correct-path fetch address; valid while o_flush=1.
o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
o_error  out  1  sticky protocol error.
o_branches  out  CNT_W  resolved-branch count.
o_mispredicts  out  CNT_W  mispredict count.

Behaviour:
- Reset: while i_Reset_n=1 at an edge, the following are all 0 on the next cycle:
  - FIFO pointers and o_count
  - o_ALU_* and o_flush
  - o_redirect_pc, o_error, o_branches, o_mispredicts
- Reset mid-operation discards all in-flight entries; no flush is generated.
- FIFO storage per entry is {pc, prediction, target}. Storage RAM is not reset.
- Pointers wrap modulo DEPTH.
- o_IF_stall = (o_count==DEPTH). The flag does not look ahead to a same-cycle pop.
- Push: i_IF_isbranch=1 and the FIFO is not full → write at the tail.
- Push while full:
  - With a same-cycle pop: the push is accepted and count is unchanged.
  - Without a pop: the push is dropped and o_error is set.
- Pop: i_EX_resolve=1 and count>0 → head entry resolved. Pop while empty: ignored, o_error set, no outputs pulse.
- Resolution latency is one cycle. For a pop at edge N, during cycle N+1:
  - o_ALU_isbranch=1
  - o_ALU_pc and o_ALU_prediction come from the entry
  - o_ALU_outcome=i_EX_outcome
  - In all other cycles o_ALU_isbranch=0 and the other o_ALU_* outputs hold their last values.
- Mispredict (prediction != outcome):
  - o_flush=1 for cycle N+1 only.
  - o_redirect_pc = outcome ? target : pc+1, computed modulo 2^PC_W, so a pc of all ones wraps to 0.
  - At edge N the whole FIFO is emptied (count=0 in N+1), including any same-cycle push, which is wrong-path.
- Correct prediction: o_flush=0; o_redirect_pc holds its value.
- Simultaneous push and pop, correct prediction: count is unchanged; the pushed entry is retained.
- Statistics:
  - o_branches increments on every valid pop.
  - o_mispredicts increments on every mispredict.
  - Both saturate at 2^CNT_W−1 and clear only on reset.
- o_error is cleared only by reset.
- State: the FIFO is the only state machine beyond the counters. Pointers are head and tail of width $clog2(DEPTH), plus the occupancy counter. Full and empty are derived from the occupancy counter.

Test Plan:
- Reset then push pc=0x10 pred=1 tgt=0x40; resolve outcome=1 → next cycle o_ALU_isbranch=1, o_ALU_pc=0x10, o_ALU_prediction=1, o_ALU_outcome=1, o_flush=0; o_branches=1; o_mispredicts=0.
- Push pc=0x20 pred=1 tgt=0x80 and pc=0x21 pred=0; resolve the first with outcome=0 → o_flush=1 for one cycle, o_redirect_pc=0x21; o_count=0 afterwards; o_mispredicts=1; pc=0x21 never appears on o_ALU_pc.
- Push pred=0 tgt=0x55 pc=0x30; resolve outcome=1 while pushing pc=0x31 → o_redirect_pc=0x55, o_flush=1; the same-cycle push is discarded; o_count=0.
- With DEPTH=4: fill 4 entries → o_IF_stall=1. A fifth push without a pop sets o_error=1, with count still 4. A fifth push with a correct-pop keeps count=4, and the FIFO order is preserved across pointer wrap.
- Resolve on empty → o_error=1, o_ALU_isbranch stays 0. Then assert i_Reset_n for one edge with 3 entries queued → count=0, o_error=0, counters=0, o_flush=0.
- Mispredict at pc=0x3FFFFF, pred=1, outcome=0 → o_redirect_pc=0x000000. With CNT_W=2, 5 resolutions → o_branches=3 (saturated).
